gmii_tx_frame_checker: RTL

//  GMII link-partner receiver for the MAC transmit path: consumes gmii_txd/tx_en/tx_er from eth_mac_1g and acts as the far end of the wire.

---
 rtl/gmii_tx_frame_checker_if.sv | 12 +
 rtl/gmii_tx_frame_checker.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/gmii_tx_frame_checker_if.sv
// GMII transmit bus between the MAC (master) and the wire-level checker (slave).
//   gmii_txd    8-bit transmit data
//   gmii_tx_en  transmit enable, high for preamble/SFD/data/FCS bytes
//   gmii_tx_er  transmit error, meaningful only while gmii_tx_en is high
interface gmii_tx_frame_checker_if;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;

  modport master (output gmii_txd, gmii_tx_en, gmii_tx_er);
  modport slave  (input  gmii_txd, gmii_tx_en, gmii_tx_er);
endinterface

// File: rtl/gmii_tx_frame_checker.sv
// Far-end GMII receiver that checks MAC transmit framing on the wire.
// It validates the preamble and SFD, the CRC-32 FCS, the frame length, the
// inter-frame gap, and tx_er. It emits one status record per frame and keeps
// saturating statistics counters.
//
// Ports:
//   clk, rst_n          GMII TX clock; async active-low reset
//   gmii (slave)        gmii_txd / gmii_tx_en / gmii_tx_er from the MAC
//   clear_stats         synchronous clear of the stat_* counters
//   frame_done          1-cycle pulse when the status fields are updated
//   frame_ok, frame_len, err_*   status of the last completed frame (held)
//   stat_frames_ok/bad, stat_bytes  saturating statistics
//
// state  | meaning
// SYNC   | after reset; wait for tx_en low so a frame in flight is ignored
// IDLE   | between frames, counting the idle gap
// PRE    | receiving preamble bytes, waiting for the SFD
// DATA   | after a good SFD; CRC and length run over every byte
// DROP   | bad preamble; consume bytes until tx_en falls
// REPORT | one cycle with frame_done high; a new frame may start here
module gmii_tx_frame_checker #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int MIN_IFG       = 12,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gmii_tx_frame_checker_if.slave gmii,
  input  logic                 clear_stats,
  output logic                 frame_done,
  output logic                 frame_ok,
  output logic [15:0]          frame_len,
  output logic                 err_preamble,
  output logic                 err_fcs,
  output logic                 err_runt,
  output logic                 err_giant,
  output logic                 err_ifg,
  output logic                 err_gmii,
  output logic [CNT_WIDTH-1:0] stat_frames_ok,
  output logic [CNT_WIDTH-1:0] stat_frames_bad,
  output logic [CNT_WIDTH-1:0] stat_bytes
);

  typedef enum logic [2:0] {SYNC, IDLE, PRE, DATA, DROP, REPORT} state_t;

  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  state_t      state_q, state_d;
  logic [2:0]  pre_cnt_q;
  logic [7:0]  ifg_cnt_q;
  logic        first_frame_q;
  logic [31:0] crc_q;
  logic [15:0] len_q;
  logic        acc_pre_q, acc_gmii_q, acc_ifg_q;

  logic frame_start, end_frame, pre_fail, sfd_hit;
  logic pre_err_total, fcs_bad, runt, giant;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SYNC;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    end_frame   = 1'b0;
    pre_fail    = 1'b0;
    sfd_hit     = 1'b0;
    case (state_q)
      SYNC: if (!gmii.gmii_tx_en) state_d = IDLE;
      IDLE, REPORT: begin
        state_d = IDLE;
        if (gmii.gmii_tx_en) begin
          frame_start = 1'b1;
          if (gmii.gmii_txd == 8'h55) begin
            state_d = PRE;
          end else begin
            pre_fail = 1'b1;
            state_d  = DROP;
          end
        end
      end
      PRE: begin
        if (!gmii.gmii_tx_en) begin
          // frame ended inside the preamble
          end_frame = 1'b1;
          pre_fail  = 1'b1;
          state_d   = REPORT;
        end else if (gmii.gmii_txd == 8'h55 && pre_cnt_q != 3'd7) begin
          state_d = PRE;
        end else if (gmii.gmii_txd == 8'hD5 && pre_cnt_q == 3'd7) begin
          sfd_hit = 1'b1;
          state_d = DATA;
        end else begin
          // an eighth 0x55, an early SFD, or any other byte
          pre_fail = 1'b1;
          state_d  = DROP;
        end
      end
      DATA, DROP: begin
        if (!gmii.gmii_tx_en) begin
          end_frame = 1'b1;
          state_d   = REPORT;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  assign pre_err_total = acc_pre_q | pre_fail;
  assign fcs_bad       = !pre_err_total && (state_q == DATA) && (crc_q != CRC_RESIDUE);
  assign runt          = len_q < 16'(MIN_FRAME_LEN);
  assign giant         = len_q > 16'(MAX_FRAME_LEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q     <= '0;
      ifg_cnt_q     <= '0;
      first_frame_q <= 1'b1;
      crc_q         <= '1;
      len_q         <= '0;
      acc_pre_q     <= 1'b0;
      acc_gmii_q    <= 1'b0;
      acc_ifg_q     <= 1'b0;
      frame_done    <= 1'b0;
      frame_ok      <= 1'b0;
      frame_len     <= '0;
      err_preamble  <= 1'b0;
      err_fcs       <= 1'b0;
      err_runt      <= 1'b0;
      err_giant     <= 1'b0;
      err_ifg       <= 1'b0;
      err_gmii      <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (frame_start) begin
        acc_ifg_q     <= !first_frame_q && (ifg_cnt_q < 8'(MIN_IFG));
        ifg_cnt_q     <= '0;
        first_frame_q <= 1'b0;
        acc_pre_q     <= pre_fail;
        acc_gmii_q    <= gmii.gmii_tx_er;
        pre_cnt_q     <= 3'd1;
        len_q         <= '0;
      end else if (end_frame) begin
        // the cycle that ends the frame is the first idle cycle
        ifg_cnt_q <= 8'd1;
      end else if (!gmii.gmii_tx_en && ifg_cnt_q != 8'hFF) begin
        ifg_cnt_q <= ifg_cnt_q + 8'd1;
      end

      if (gmii.gmii_tx_en && (state_q == PRE || state_q == DATA || state_q == DROP)) begin
        if (gmii.gmii_tx_er) acc_gmii_q <= 1'b1;
      end

      if (state_q == PRE && gmii.gmii_tx_en) begin
        if (pre_fail) acc_pre_q <= 1'b1;
        if (gmii.gmii_txd == 8'h55 && pre_cnt_q != 3'd7) pre_cnt_q <= pre_cnt_q + 3'd1;
        if (sfd_hit) begin
          crc_q <= '1;
          len_q <= '0;
        end
      end

      if (state_q == DATA && gmii.gmii_tx_en) begin
        crc_q <= crc_byte(crc_q, gmii.gmii_txd);
        if (len_q != 16'hFFFF) len_q <= len_q + 16'd1;
      end

      if (end_frame) begin
        frame_done   <= 1'b1;
        frame_len    <= len_q;
        err_preamble <= pre_err_total;
        err_fcs      <= fcs_bad;
        err_runt     <= runt;
        err_giant    <= giant;
        err_ifg      <= acc_ifg_q;
        err_gmii     <= acc_gmii_q;
        frame_ok     <= !(pre_err_total | fcs_bad | runt | giant | acc_ifg_q | acc_gmii_q);
      end
    end
  end

  logic [CNT_WIDTH:0] bytes_sum;
  assign bytes_sum = {1'b0, stat_bytes} + {{(CNT_WIDTH-15){1'b0}}, frame_len};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames_ok  <= '0;
      stat_frames_bad <= '0;
      stat_bytes      <= '0;
    end else if (clear_stats) begin
      stat_frames_ok  <= '0;
      stat_frames_bad <= '0;
      stat_bytes      <= '0;
    end else if (state_q == REPORT) begin
      if (frame_ok) begin
        if (stat_frames_ok != '1) stat_frames_ok <= stat_frames_ok + 1'b1;
      end else begin
        if (stat_frames_bad != '1) stat_frames_bad <= stat_frames_bad + 1'b1;
      end
      stat_bytes <= bytes_sum[CNT_WIDTH] ? '1 : bytes_sum[CNT_WIDTH-1:0];
    end
  end

endmodule
